// File: rtl/uart_frame_parser.sv
// Command-frame parser behind the UART byte receiver: SOF, LEN, CMD, payload, XOR checksum.
// Optional inter-byte timeout is compiled in when FRAME_TIMEOUT_EN is defined.
module uart_frame_parser #(
   parameter logic [7:0] SOF         = 8'hAA,
   parameter int          MAX_LEN     = 16,
   parameter int          AW          = 4,
   parameter int          TIMEOUT_CYC = 500000
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          rx_busy,
   input  logic [7:0]    rx_data,
   input  logic [AW-1:0] rd_addr,
   output logic [7:0]    rd_data,
   output logic          frame_ready,
   output logic [7:0]    frame_cmd,
   output logic [AW:0]   frame_len,
   input  logic          frame_ack,
   output logic          frame_err,
   output logic [1:0]    err_code,
   output logic [7:0]    drop_cnt
);

   localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);
   localparam logic [AW:0] IDX_ONE   = (AW+1)'(1);

   localparam logic [1:0] ERR_LEN     = 2'b01;
   localparam logic [1:0] ERR_CHK     = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT = 2'b11;

   if (TIMEOUT_CYC < 2 || MAX_LEN < 1 || MAX_LEN > 255 || (1 << AW) < MAX_LEN) begin : g_cfg_check
      $error("uart_frame_parser: inconsistent MAX_LEN/AW/TIMEOUT_CYC");
   end

   typedef enum logic [2:0] {
      S_HUNT,
      S_LEN,
      S_CMD,
      S_PAY,
      S_CHK,
      S_HOLD
   } state_t;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   state_t      state, state_nxt;
   logic        rx_busy_d;
   logic        byte_stb;
   logic        len_ok;
   logic        timeout;

   logic        err_fire;
   logic [1:0]  err_val;
   logic        accept;
   logic        drop;

   logic [AW:0] len_q;
   logic [7:0]  cmd_q;
   logic [7:0]  chk_q;
   logic [AW:0] idx_q;
   logic [7:0]  pay_mem [0:(1<<AW)-1];

   assign byte_stb = rx_busy_d & ~rx_busy;
   assign len_ok   = (rx_data != 8'h00) && (rx_data <= MAX_LEN_B);

   always_comb begin
      state_nxt = state;
      err_fire  = 1'b0;
      err_val   = 2'b00;
      accept    = 1'b0;
      drop      = 1'b0;
      case (state)
         S_HUNT: if (byte_stb && rx_data == SOF) state_nxt = S_LEN;
         S_LEN: begin
            if (byte_stb) begin
               if (len_ok) begin
                  state_nxt = S_CMD;
               end else begin
                  err_fire  = 1'b1;
                  err_val   = ERR_LEN;
                  state_nxt = S_HUNT;
               end
            end
         end
         S_CMD: if (byte_stb) state_nxt = S_PAY;
         // SOF inside the payload is plain data; only the byte count ends PAY.
         S_PAY: if (byte_stb && (idx_q + IDX_ONE) == len_q) state_nxt = S_CHK;
         S_CHK: begin
            if (byte_stb) begin
               if (rx_data == chk_q) begin
                  accept    = 1'b1;
                  state_nxt = S_HOLD;
               end else begin
                  err_fire  = 1'b1;
                  err_val   = ERR_CHK;
                  state_nxt = S_HUNT;
               end
            end
         end
         S_HOLD: begin
            drop = byte_stb;
            if (frame_ack) state_nxt = S_HUNT;
         end
         default: state_nxt = S_HUNT;
      endcase
      if (timeout) begin
         err_fire  = 1'b1;
         err_val   = ERR_TIMEOUT;
         state_nxt = S_HUNT;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_HUNT;
         rx_busy_d   <= 1'b0;
         frame_ready <= 1'b0;
         frame_err   <= 1'b0;
         err_code    <= 2'b00;
         drop_cnt    <= 8'h00;
         frame_cmd   <= 8'h00;
         frame_len   <= '0;
         rd_data     <= 8'h00;
      end else begin
         state     <= state_nxt;
         rx_busy_d <= rx_busy;
         frame_err <= err_fire;
         if (err_fire) err_code <= err_val;
         if (drop) drop_cnt <= sat_inc8(drop_cnt);
         if (accept) begin
            frame_ready <= 1'b1;
            frame_cmd   <= cmd_q;
            frame_len   <= len_q;
         end else if (state == S_HOLD && frame_ack) begin
            frame_ready <= 1'b0;
         end
         rd_data <= ({1'b0, rd_addr} < frame_len) ? pay_mem[rd_addr] : 8'h00;
      end
   end

   // Frame assembly registers carry no reset; each is written before it is used.
   always_ff @(posedge clk) begin
      if (byte_stb) begin
         case (state)
            S_LEN: begin
               len_q <= rx_data[AW:0];
               chk_q <= rx_data;
            end
            S_CMD: begin
               cmd_q <= rx_data;
               chk_q <= chk_q ^ rx_data;
               idx_q <= '0;
            end
            S_PAY: begin
               pay_mem[idx_q[AW-1:0]] <= rx_data;
               chk_q                  <= chk_q ^ rx_data;
               idx_q                  <= idx_q + IDX_ONE;
            end
            default: ;
         endcase
      end
   end

`ifdef FRAME_TIMEOUT_EN
   localparam int             TW   = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0]  TMAX = TW'(TIMEOUT_CYC - 1);

   logic [TW-1:0] tcnt;
   logic          in_frame;

   assign in_frame = (state == S_LEN) || (state == S_CMD) || (state == S_PAY) || (state == S_CHK);
   // A byte arriving on the expiry cycle wins over the timeout.
   assign timeout  = in_frame && !byte_stb && (tcnt == TMAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tcnt <= '0;
      end else if (byte_stb || state == S_HUNT || state == S_HOLD) begin
         tcnt <= '0;
      end else begin
         tcnt <= tcnt + TW'(1);
      end
   end
`else
   assign timeout = 1'b0;
`endif

endmodule
